// File: rtl/md5_hash_op.sv
// md5_hash_op: registered single MD5 step with elaboration-time round function, add, rotate and word shuffle
module md5_hash_op #(
  parameter int          index = 0,
  parameter int          s     = 7,
  parameter logic [31:0] k     = 32'hd76aa478
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        en,
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  logic [31:0] c,
  input  logic [31:0] d,
  input  logic [31:0] m,
  output logic [31:0] a_out,
  output logic [31:0] b_out,
  output logic [31:0] c_out,
  output logic [31:0] d_out
);
  logic [31:0] w_f;
  logic [31:0] w_t;
  logic [31:0] w_r;
  logic [31:0] r_a;
  logic [31:0] r_b;
  logic [31:0] r_c;
  logic [31:0] r_d;
  // round function picked by step number; anything past 63 falls through to I
  always_comb begin
    w_f = (index < 16) ? ((b & c) | (~b & d)) :
          (index < 32) ? ((b & d) | (c & ~d)) :
          (index < 48) ? (b ^ c ^ d) :
                         (c ^ (b | ~d));
    w_t = a + w_f + k + m;
    w_r = (s % 32 == 0) ? w_t : ((w_t << (s % 32)) | (w_t >> (32 - s % 32)));
  end
  // working registers advance only on enabled edges; reset clears them at once
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_a <= '0;
      r_b <= '0;
      r_c <= '0;
      r_d <= '0;
    end else if (en) begin
      r_a <= d;
      r_b <= b + w_r;
      r_c <= b;
      r_d <= c;
    end
  end
  assign a_out = r_a;
  assign b_out = r_b;
  assign c_out = r_c;
  assign d_out = r_d;
endmodule

// File: tb/tb_md5_hash_op.sv
// tb_md5_hash_op: directed checks of one MD5 step across the four round functions, enable gating and async reset
module tb_md5_hash_op;
  logic        clk = 0;
  logic        reset = 0;
  logic        en = 0;
  logic [31:0] a = 0, b = 0, c = 0, d = 0, m = 0;
  logic [31:0] a0, b0, c0, d0;
  logic [31:0] a16, b16, c16, d16;
  logic [31:0] a32, b32, c32, d32;
  logic [31:0] a48, b48, c48, d48;
  logic [31:0] a70, b70, c70, d70;
  int checks = 0;
  int failures = 0;

  md5_hash_op #(.index(0), .s(7), .k(32'hd76aa478)) u0 (
    .clk(clk), .reset(reset), .en(en), .a(a), .b(b), .c(c), .d(d), .m(m),
    .a_out(a0), .b_out(b0), .c_out(c0), .d_out(d0));
  md5_hash_op #(.index(16), .s(5), .k(32'h0)) u16 (
    .clk(clk), .reset(reset), .en(en), .a(a), .b(b), .c(c), .d(d), .m(m),
    .a_out(a16), .b_out(b16), .c_out(c16), .d_out(d16));
  md5_hash_op #(.index(32), .s(4), .k(32'h0)) u32 (
    .clk(clk), .reset(reset), .en(en), .a(a), .b(b), .c(c), .d(d), .m(m),
    .a_out(a32), .b_out(b32), .c_out(c32), .d_out(d32));
  md5_hash_op #(.index(48), .s(10), .k(32'h0)) u48 (
    .clk(clk), .reset(reset), .en(en), .a(a), .b(b), .c(c), .d(d), .m(m),
    .a_out(a48), .b_out(b48), .c_out(c48), .d_out(d48));
  md5_hash_op #(.index(70), .s(0), .k(32'h0)) u70 (
    .clk(clk), .reset(reset), .en(en), .a(a), .b(b), .c(c), .d(d), .m(m),
    .a_out(a70), .b_out(b70), .c_out(c70), .d_out(d70));

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [31:0] na, input logic [31:0] nb, input logic [31:0] nc,
                       input logic [31:0] nd, input logic [31:0] nm);
    a = na; b = nb; c = nc; d = nd; m = nm;
  endtask

  initial begin
    #2;
    chk("rst_a0", a0, 32'h0);
    chk("rst_b0", b0, 32'h0);
    chk("rst_c0", c0, 32'h0);
    chk("rst_d0", d0, 32'h0);
    en = 1;
    drive(32'h67452301, 32'hefcdab89, 32'h98badcfe, 32'h10325476, 32'h20656854);
    repeat (3) step();
    chk("rst_hold_b0", b0, 32'h0);
    chk("rst_hold_a0", a0, 32'h0);
    reset = 1;
    step();
    chk("t1_a0", a0, 32'h10325476);
    chk("t1_b0", b0, 32'hd7d41184);
    chk("t1_c0", c0, 32'hefcdab89);
    chk("t1_d0", d0, 32'h98badcfe);
    chk("idx70_s0_b", b70, 32'heeefae55);
    en = 0;
    drive(32'hffffffff, 32'h0, 32'h0, 32'hffffffff, 32'hffffffff);
    for (int i = 0; i < 5; i++) begin
      step();
      chk("hold_a0", a0, 32'h10325476);
      chk("hold_b0", b0, 32'hd7d41184);
    end
    en = 1;
    step();
    chk("wrap_a0", a0, 32'hffffffff);
    chk("wrap_b0", b0, 32'hb5523aeb);
    chk("wrap_c0", c0, 32'h0);
    chk("wrap_d0", d0, 32'h0);
    drive(32'h1, 32'hffffffff, 32'h0, 32'hffffffff, 32'h0);
    step();
    chk("g_a16", a16, 32'hffffffff);
    chk("g_b16", b16, 32'hffffffff);
    chk("g_c16", c16, 32'hffffffff);
    chk("g_d16", d16, 32'h0);
    drive(32'h0, 32'h1, 32'h2, 32'h4, 32'h0);
    step();
    chk("h_a32", a32, 32'h4);
    chk("h_b32", b32, 32'h71);
    chk("h_c32", c32, 32'h1);
    chk("h_d32", d32, 32'h2);
    drive(32'h0, 32'h0, 32'h0, 32'h0, 32'h0);
    step();
    chk("i_a48", a48, 32'h0);
    chk("i_b48", b48, 32'hffffffff);
    chk("i_c48", c48, 32'h0);
    chk("i_d48", d48, 32'h0);
    drive(32'h67452301, 32'hefcdab89, 32'h98badcfe, 32'h10325476, 32'h20656854);
    step();
    chk("pre_rst_b0", b0, 32'hd7d41184);
    #2 reset = 0;
    #1;
    chk("async_a0", a0, 32'h0);
    chk("async_b0", b0, 32'h0);
    chk("async_c0", c0, 32'h0);
    chk("async_d0", d0, 32'h0);
    step();
    step();
    chk("rst_en_b0", b0, 32'h0);
    chk("rst_en_a0", a0, 32'h0);
    en = 0;
    reset = 1;
    step();
    chk("rel_noen_b0", b0, 32'h0);
    en = 1;
    step();
    chk("rel_en_b0", b0, 32'hd7d41184);
    chk("rel_en_a0", a0, 32'h10325476);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
